// File: rtl/cpu_ctrl_pkg.sv
// Shared types and widths for the teaching-CPU run controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_e;

    localparam int PC_W  = 4;
    localparam int CNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, rising-edge press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step/breakpoint controller producing the CPU clock-enable.
// Breakpoint support is built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RATE      = 1_000_000,
    parameter int DB_CYCLES = 50_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int DIV_W = (RATE > 1) ? $clog2(RATE) : 1;

    logic run_press, step_press;
    logic run_lvl_unused, step_lvl_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (run_btn),
        .level   (run_lvl_unused),
        .press   (run_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (step_btn),
        .level   (step_lvl_unused),
        .press   (step_press)
    );

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               en_q, en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    logic               bp_hit;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic skip_q, skip_d;
    assign bp_hit = bp_valid && (pc == bp_addr) && !skip_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid, pc};
    assign bp_hit    = 1'b0;
`endif

    assign tick = (state_q == RUN) && (div_q == DIV_W'(RATE - 1));

    // Run press always takes priority over a step press in the same cycle.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        en_d    = 1'b0;
        cnt_d   = cnt_q + CNT_W'(en_q);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        skip_d  = skip_q;
`endif
        case (state_q)
            HALT: begin
                div_d = '0;
                if (run_press) begin
                    state_d = RUN;
                end else if (step_press) begin
                    state_d = STEP;
                    en_d    = 1'b1;
                end
            end
            STEP: begin
                state_d = HALT;
            end
            RUN: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (run_press) begin
                    state_d = HALT;
                    div_d   = '0;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = BRK;
                    end else begin
                        en_d = 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                        skip_d = 1'b0;
`endif
                    end
                end
            end
            BRK: begin
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                if (run_press) begin
                    state_d = RUN;
                    div_d   = '0;
                    skip_d  = 1'b1;
                end else if (step_press) begin
                    state_d = STEP;
                    en_d    = 1'b1;
                end
`else
                state_d = HALT;
`endif
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HALT;
            div_q   <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            skip_q  <= skip_d;
`endif
        end
    end

    assign cpu_en   = en_q;
    assign state    = state_q;
    assign halted   = (state_q != RUN);
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with RATE=4, DB_CYCLES=3 and a +1-per-enable pc model.
module tb_cpu_run_ctrl;

    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_BRK  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic [3:0] pc;
    logic [3:0] bp_addr = 4'd0;
    logic       bp_valid = 1'b0;
    logic       cpu_en;
    logic [1:0] state;
    logic       halted;
    logic [7:0] step_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic [1:0] st;
        logic       en;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    cpu_run_ctrl #(.RATE(4), .DB_CYCLES(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .pc       (pc),
        .bp_addr  (bp_addr),
        .bp_valid (bp_valid),
        .cpu_en   (cpu_en),
        .state    (state),
        .halted   (halted),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // CPU model: pc advances by one for every enabled cycle.
    always @(posedge clk) begin
        if (!reset) pc <= 4'd0;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        step_cycle();
        step_cycle();
        reset = 1'b1;
        step_cycle();
    endtask

    task automatic check_idle(input int cyc);
        check("state", cyc, 32'(state), 32'(S_HALT));
        check("cpu_en", cyc, 32'(cpu_en), 32'd0);
    endtask

    initial begin
        logic       exp_en;
        logic [1:0] exp_st;

        for (int k = 0; k < 12; k++) begin
            tbl[k].run  = 1'b0;
            tbl[k].step = (k < 8);
            tbl[k].st   = (k == 5) ? S_STEP : S_HALT;
            tbl[k].en   = (k == 5);
            tbl[k].cnt  = (k >= 6) ? 8'd1 : 8'd0;
        end

        // Reset values.
        do_reset();
        check("rst_state", 0, 32'(state), 32'(S_HALT));
        check("rst_halted", 0, 32'(halted), 32'd1);
        check("rst_cpu_en", 0, 32'(cpu_en), 32'd0);
        check("rst_step_cnt", 0, 32'(step_cnt), 32'd0);

        // Single step from a held button.
        for (int k = 0; k < 12; k++) begin
            run_btn  = tbl[k].run;
            step_btn = tbl[k].step;
            step_cycle();
            check("step_state", k, 32'(state), 32'(tbl[k].st));
            check("step_en", k, 32'(cpu_en), 32'(tbl[k].en));
            check("step_cnt", k, 32'(step_cnt), 32'(tbl[k].cnt));
        end
        check("step_pc", 0, 32'(pc), 32'd1);
        check("step_halted", 0, 32'(halted), 32'd1);

        // Free run, then a stop press landing in a tick cycle.
        do_reset();
        run_btn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step_cycle();
            check_idle(i);
        end
        step_cycle();
        check("run_enter", 0, 32'(state), 32'(S_RUN));
        check("run_halted", 0, 32'(halted), 32'd0);
        run_btn = 1'b0;
        for (int r = 1; r <= 24; r++) begin
            step_cycle();
            exp_en = (r == 4 || r == 8 || r == 12);
            exp_st = (r < 16) ? S_RUN : S_HALT;
            check("run_en", r, 32'(cpu_en), 32'(exp_en));
            check("run_state", r, 32'(state), 32'(exp_st));
            if (r == 10) run_btn = 1'b1;
            if (r == 18) run_btn = 1'b0;
        end
        check("run_cnt", 0, 32'(step_cnt), 32'd3);
        check("run_pc", 0, 32'(pc), 32'd3);

        // Breakpoint at pc 3, then resume past it.
        do_reset();
        bp_valid = 1'b1;
        bp_addr  = 4'd3;
        run_btn  = 1'b1;
        for (int i = 1; i <= 6; i++) step_cycle();
        check("bp_enter", 0, 32'(state), 32'(S_RUN));
        run_btn = 1'b0;
        for (int r = 1; r <= 36; r++) begin
            step_cycle();
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            exp_en = (r == 4 || r == 8 || r == 12 || r == 30 || r == 34);
            exp_st = (r < 16) ? S_RUN : ((r < 26) ? S_BRK : S_RUN);
            if (r >= 16 && r <= 25) check("bp_pc_held", r, 32'(pc), 32'd3);
`else
            exp_en = (r % 4 == 0) && (r <= 24);
            exp_st = (r < 26) ? S_RUN : S_HALT;
`endif
            check("bp_en", r, 32'(cpu_en), 32'(exp_en));
            check("bp_state", r, 32'(state), 32'(exp_st));
            if (r == 20) run_btn = 1'b1;
            if (r == 26) run_btn = 1'b0;
        end
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        check("bp_pc_end", 0, 32'(pc), 32'd5);
        check("bp_cnt_end", 0, 32'(step_cnt), 32'd5);
`else
        check("bp_pc_end", 0, 32'(pc), 32'd6);
        check("bp_cnt_end", 0, 32'(step_cnt), 32'd6);
`endif
        bp_valid = 1'b0;

        // Bouncing run button never settles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_btn = (i % 2 == 0);
            step_cycle();
            check_idle(i);
        end
        run_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            check_idle(10 + i);
        end

        // Run and step accepted together: run wins.
        do_reset();
        run_btn  = 1'b1;
        step_btn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step_cycle();
            check_idle(i);
        end
        for (int i = 6; i <= 9; i++) begin
            step_cycle();
            check("both_state", i, 32'(state), 32'(S_RUN));
            check("both_en", i, 32'(cpu_en), 32'd0);
        end
        check("both_cnt", 0, 32'(step_cnt), 32'd0);
        run_btn  = 1'b0;
        step_btn = 1'b0;

        // Reset asserted while running.
        reset = 1'b0;
        step_cycle();
        check("mid_rst_state", 0, 32'(state), 32'(S_HALT));
        check("mid_rst_halted", 0, 32'(halted), 32'd1);
        check("mid_rst_cnt", 0, 32'(step_cnt), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_cycle();
            check_idle(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution controller for the 8-register, 4-bit teaching CPU. It generates the CPU's clock-enable, `cpu_en`, and drives the CPU through four modes: halt, free-run at a divided rate, single-step from a push button, and stop on a program-counter breakpoint. It sits between the board buttons and the CPU, and it observes the CPU's program counter. The block never drives the CPU reset.

## Interface
Parameters:
- `RATE`, default 1_000_000: `clk` cycles between consecutive `cpu_en` pulses in RUN; must be ≥ 2.
- `DB_CYCLES`, default 50_000: consecutive stable cycles required before a button level is accepted.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `run_btn` in 1: raw asynchronous button; each press toggles run/halt.
- `step_btn` in 1: raw asynchronous button; each press requests one instruction.
- `pc` in 4: low four bits of the CPU program counter.
- `bp_addr` in 4: breakpoint address.
- `bp_valid` in 1: breakpoint armed.
- `cpu_en` out 1: registered one-cycle instruction enable.
- `state` out 2: current FSM state.
- `halted` out 1: high when `state` ≠ RUN.
- `step_cnt` out 8: count of `cpu_en` pulses; wraps 255→0.

## Operation
Button path:
- Each button goes through a 2-flop synchronizer, then a debounce counter.
- A new level is accepted after `DB_CYCLES` consecutive equal samples.
- A rising edge of the accepted level produces a one-cycle press event.

FSM states:
- HALT=00: run press → RUN, divider cleared. Step press → STEP.
- STEP=10: `cpu_en`=1 for exactly this one cycle, then → HALT. Presses in STEP are discarded.
- RUN=01:
  - Divider counts 0..RATE-1 and wraps. The cycle where divider = RATE-1 is a tick.
  - A tick asserts `cpu_en`, unless a breakpoint hit occurs: then no pulse and → BRK.
  - Run press → HALT; a tick in that same cycle is suppressed.
  - Step press is ignored.
- BRK=11:
  - Run press → RUN with the skip flag set; the first tick ignores the breakpoint.
  - Step press → STEP.

Breakpoint and arbitration:
- Breakpoint hit = `bp_valid` & (`pc` == `bp_addr`), evaluated only on a tick, and only when skip is clear. Skip clears on the first issued tick.
- Simultaneous run and step press: run wins; the step press is dropped.

Reset and counters:
- Reset values: state HALT, `cpu_en` 0, `halted` 1, `step_cnt` 0, divider 0, skip 0, synchronizers and debounced levels 0, debounce counters 0.
- Reset asserted mid-operation: all of the above take effect on that same edge, and any pending tick is lost.
- `step_cnt` increments on every cycle in which `cpu_en`=1.

## Timing
- `cpu_en` is a flop output and is never high two cycles in a row.
- `pc` is stable while `cpu_en` is low and is sampled in the tick cycle.
- Button to press event: 2 synchronizer cycles + `DB_CYCLES` + 1 cycle.
- Press event at edge N → state change visible at N+1. For STEP, `cpu_en` is high during N+1.
- First RUN pulse occurs `RATE` cycles after entering RUN; subsequent pulses are exactly `RATE` apart.
- A `bp_addr` or `bp_valid` change takes effect at the next tick.

## Configuration
- Macro `CPU_RUN_CTRL_BREAKPOINT_EN`.
- Defined: breakpoint logic, skip flag and BRK state are present, as described above.
- Undefined:
  - `bp_addr` and `bp_valid` are ignored.
  - BRK is unreachable and the skip flag is removed.
  - RUN issues a pulse on every tick.
  - Port list is unchanged.

## Structure
- Package `cpu_ctrl_pkg`:
  - state enum: HALT=2'b00, RUN=2'b01, STEP=2'b10, BRK=2'b11.
  - `PC_W`=4 and `CNT_W`=8 constants.
- Sub-module `btn_debounce`:
  - Parameter `DB_CYCLES`.
  - Ports `clk`, `reset`, `btn_raw`, `level`, `press`.
  - Instantiated twice.
- FSM, divider, breakpoint compare and `step_cnt` live in `cpu_run_ctrl`.

## Test plan
All scenarios use RATE=4 and DB_CYCLES=3. The bench models the CPU pc as +1 per `cpu_en`, starting from 0.
- Reset low for 2 cycles, then high → `state`=00, `halted`=1, `cpu_en`=0, `step_cnt`=0.
- `step_btn` high for 8 cycles → exactly one `cpu_en` pulse; `state` returns to 00; `step_cnt`=1; pc=1.
- Run press, then 12 cycles → 3 pulses spaced 4 cycles apart. Second run press → `state`=00 and no further pulses, including in a coinciding tick cycle.
- Breakpoint armed with `bp_valid`=1, `bp_addr`=3; run press → pulses at pc 0,1,2, then `state`=11 with pc=3 held. Run press again → next tick issues at pc=3, then pc=4, with no re-break.
- `run_btn` toggling every cycle for 10 cycles, then low → no press event; `state` stays 00.
- In HALT, run and step debounced on the same cycle → `state`=01 and no STEP pulse.
